// File: rtl/dmem_ctrl.sv
// Data-memory responder for the RV32 M stage: a multi-cycle synchronous RAM with
// byte/half/word access, load extension, a pipeline stall while busy and a misalign pulse.
module dmem_ctrl #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        MemReadM,
   input  logic        MemWriteM,
   input  logic [31:0] AddrM,
   input  logic [31:0] WriteDataM,
   input  logic [2:0]  Funct3M,
   output logic [31:0] ReadDataM,
   output logic        StallMem,
   output logic        MisalignM
);

   localparam int AW    = $clog2(DEPTH_WORDS);
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   // Request/stall handshake: the M stage holds MemReadM/MemWriteM and its operands
   // while StallMem is high. A request is accepted in IDLE (StallMem rises in that same
   // cycle), the RAM is accessed at the last WAIT edge, and in DONE StallMem is low so
   // the stage advances; the still-visible request in DONE is the finished one, ignored.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_WAIT = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [AW+1:0]     addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [2:0]        funct3_q, funct3_d;
   logic              is_store_q, is_store_d;
   logic [31:0]       rdata_q, rdata_d;
   logic              misalign_q, misalign_d;

   logic [31:0]       mem_q [DEPTH_WORDS];

   logic              req;
   logic              aligned;
   logic              do_access;
   logic [AW-1:0]     idx;
   logic [31:0]       rd_word;
   logic [7:0]        byte_sel;
   logic [15:0]       half_sel;
   logic [31:0]       ld_val;
   logic [31:0]       wr_word;
   logic [3:0]        be;
   logic              unused_addr_hi;

   // Upper address bits do not select anything: addresses wrap modulo the RAM size.
   assign unused_addr_hi = ^AddrM[31:AW+2];

   always_comb begin
      req     = MemReadM | MemWriteM;
      aligned = 1'b1;
      case (Funct3M[1:0])
         2'b00:   aligned = 1'b1;
         2'b01:   aligned = ~AddrM[0];
         default: aligned = (AddrM[1:0] == 2'b00);
      endcase
   end

   // Access path, driven entirely from captured request fields.
   always_comb begin
      idx       = addr_q[AW+1:2];
      rd_word   = mem_q[idx];
      do_access = (state_q == S_WAIT) && (cnt_q == '0);
      byte_sel  = rd_word[{addr_q[1:0], 3'b000} +: 8];
      half_sel  = addr_q[1] ? rd_word[31:16] : rd_word[15:0];
      be        = 4'b1111;
      wr_word   = wdata_q;
      case (funct3_q[1:0])
         2'b00: begin
            be      = 4'b0001 << addr_q[1:0];
            wr_word = {4{wdata_q[7:0]}};
         end
         2'b01: begin
            be      = addr_q[1] ? 4'b1100 : 4'b0011;
            wr_word = {2{wdata_q[15:0]}};
         end
         default: begin
            be      = 4'b1111;
            wr_word = wdata_q;
         end
      endcase
      case (funct3_q)
         3'b000:  ld_val = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  ld_val = {{16{half_sel[15]}}, half_sel};
         3'b100:  ld_val = {24'd0, byte_sel};
         3'b101:  ld_val = {16'd0, half_sel};
         default: ld_val = rd_word;
      endcase
   end

   // Reset wins over a store whose access edge coincides with it; contents are kept.
   always_ff @(posedge clk) begin
      if (!reset && do_access && is_store_q) begin
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mem_q[idx][8*i +: 8] <= wr_word[8*i +: 8];
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      funct3_d   = funct3_q;
      is_store_d = is_store_q;
      rdata_d    = rdata_q;
      misalign_d = 1'b0;
      StallMem   = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               if (aligned) begin
                  StallMem   = 1'b1;
                  addr_d     = AddrM[AW+1:0];
                  wdata_d    = WriteDataM;
                  funct3_d   = Funct3M;
                  is_store_d = MemWriteM;
                  cnt_d      = CNT_W'(LATENCY - 1);
                  state_d    = S_WAIT;
               end else begin
                  misalign_d = 1'b1;
               end
            end
         end
         S_WAIT: begin
            StallMem = 1'b1;
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               state_d = S_DONE;
               if (!is_store_q) rdata_d = ld_val;
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         addr_q     <= '0;
         wdata_q    <= '0;
         funct3_q   <= '0;
         is_store_q <= 1'b0;
         rdata_q    <= '0;
         misalign_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         addr_q     <= addr_d;
         wdata_q    <= wdata_d;
         funct3_q   <= funct3_d;
         is_store_q <= is_store_d;
         rdata_q    <= rdata_d;
         misalign_q <= misalign_d;
      end
   end

   assign ReadDataM = rdata_q;
   assign MisalignM = misalign_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: directed vector table, a reset-mid-store sequence, and random
// traffic checked against a byte-addressed memory model.
module tb_dmem_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemReadM, MemWriteM;
   logic [31:0] AddrM, WriteDataM;
   logic [2:0]  Funct3M;
   logic [31:0] ReadDataM;
   logic        StallMem, MisalignM;

   int n_pass  = 0;
   int n_total = 0;

   always #5 clk = ~clk;

   dmem_ctrl #(.DEPTH_WORDS(1024), .LATENCY(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .MemReadM   (MemReadM),
      .MemWriteM  (MemWriteM),
      .AddrM      (AddrM),
      .WriteDataM (WriteDataM),
      .Funct3M    (Funct3M),
      .ReadDataM  (ReadDataM),
      .StallMem   (StallMem),
      .MisalignM  (MisalignM)
   );

   typedef struct {
      string       name;
      logic        rd;
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [2:0]  f3;
      int          exp_stall;
      logic        exp_mis;
      logic [31:0] exp_data;
   } vec_t;

   vec_t        vecs[$];
   logic [31:0] exp_q[$];
   logic [7:0]  model_mem [4096];
   logic [31:0] model_last;

   function automatic vec_t mk(string nm, logic rd, logic wr, logic [31:0] a, logic [31:0] wd,
                               logic [2:0] f3, int st, logic mis, logic [31:0] ed);
      vec_t v;
      v.name = nm; v.rd = rd; v.wr = wr; v.addr = a; v.wdata = wd; v.f3 = f3;
      v.exp_stall = st; v.exp_mis = mis; v.exp_data = ed;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
   endtask

   task automatic clear_inputs();
      MemReadM = 1'b0; MemWriteM = 1'b0; AddrM = '0; WriteDataM = '0; Funct3M = '0;
   endtask

   // Holds the request while stalled (and through DONE), then drops it. Returns the stall
   // length, ReadDataM after completion, the misalign pulse and its width follow-up.
   task automatic do_op(input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] wd, input logic [2:0] f3,
                        output int stalls, output logic [31:0] rdata,
                        output logic mis, output logic mis_after, output logic timeout);
      stalls = 0; mis = 1'b0; mis_after = 1'b0; timeout = 1'b0;
      @(negedge clk);
      MemReadM = rd; MemWriteM = wr; AddrM = a; WriteDataM = wd; Funct3M = f3;
      #1;
      while (StallMem && !timeout) begin
         stalls++;
         @(negedge clk); #1;
         mis = mis | MisalignM;
         if (stalls > 40) timeout = 1'b1;
      end
      if (stalls == 0) begin
         @(negedge clk); clear_inputs(); #1;
         mis   = MisalignM;
         rdata = ReadDataM;
         @(negedge clk); #1;
         mis_after = MisalignM;
      end else begin
         rdata = ReadDataM;
         @(negedge clk); clear_inputs(); #1;
      end
   endtask

   function automatic int size_of(logic [2:0] f3);
      return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
   endfunction

   function automatic logic [31:0] model_load(logic [31:0] a, logic [2:0] f3);
      int      n = size_of(f3);
      longint  v = 0;
      for (int i = 0; i < n; i++) v += longint'(model_mem[(a + i) % 4096]) << (8 * i);
      if (!f3[2] && n < 4 && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
      return v[31:0];
   endfunction

   initial begin
      int          st;
      logic [31:0] rdv;
      logic        mis, mis2, to;
      logic [2:0]  ld_f3 [5];
      ld_f3 = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

      clear_inputs();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("reset_rdata", ReadDataM, 32'h0);
      chk("reset_stall", {31'd0, StallMem}, 32'd0);
      chk("reset_mis", {31'd0, MisalignM}, 32'd0);

      vecs.push_back(mk("sw_10",      0, 1, 32'h10,   32'hDEADBEEF, 3'b010, 3, 0, 32'h0));
      vecs.push_back(mk("lw_10",      1, 0, 32'h10,   32'h0,        3'b010, 3, 0, 32'hDEADBEEF));
      vecs.push_back(mk("lb_13",      1, 0, 32'h13,   32'h0,        3'b000, 3, 0, 32'hFFFFFFDE));
      vecs.push_back(mk("lbu_13",     1, 0, 32'h13,   32'h0,        3'b100, 3, 0, 32'h000000DE));
      vecs.push_back(mk("lh_12",      1, 0, 32'h12,   32'h0,        3'b001, 3, 0, 32'hFFFFDEAD));
      vecs.push_back(mk("lhu_10",     1, 0, 32'h10,   32'h0,        3'b101, 3, 0, 32'h0000BEEF));
      vecs.push_back(mk("sb_11",      0, 1, 32'h11,   32'h123456AA, 3'b000, 3, 0, 32'h0000BEEF));
      vecs.push_back(mk("lw_after_sb",1, 0, 32'h10,   32'h0,        3'b010, 3, 0, 32'hDEADAAEF));
      vecs.push_back(mk("sh_12",      0, 1, 32'h12,   32'h0000CAFE, 3'b001, 3, 0, 32'hDEADAAEF));
      vecs.push_back(mk("lw_after_sh",1, 0, 32'h10,   32'h0,        3'b010, 3, 0, 32'hCAFEAAEF));
      vecs.push_back(mk("lw_12_mis",  1, 0, 32'h12,   32'h0,        3'b010, 0, 1, 32'hCAFEAAEF));
      vecs.push_back(mk("sh_11_mis",  0, 1, 32'h11,   32'h00009999, 3'b001, 0, 1, 32'hCAFEAAEF));
      vecs.push_back(mk("lw_10_kept", 1, 0, 32'h10,   32'h0,        3'b010, 3, 0, 32'hCAFEAAEF));
      vecs.push_back(mk("sw_1000",    0, 1, 32'h1000, 32'h0BADF00D, 3'b010, 3, 0, 32'hCAFEAAEF));
      vecs.push_back(mk("lw_0_wrap",  1, 0, 32'h0,    32'h0,        3'b010, 3, 0, 32'h0BADF00D));
      vecs.push_back(mk("rdwr_4",     1, 1, 32'h4,    32'h5,        3'b010, 3, 0, 32'h0BADF00D));
      vecs.push_back(mk("lw_4",       1, 0, 32'h4,    32'h0,        3'b010, 3, 0, 32'h00000005));

      foreach (vecs[i]) begin
         do_op(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].f3, st, rdv, mis, mis2, to);
         chk({vecs[i].name, "_timeout"}, {31'd0, to}, 32'd0);
         chk({vecs[i].name, "_stall"}, 32'(st), 32'(vecs[i].exp_stall));
         chk({vecs[i].name, "_mis"}, {31'd0, mis}, {31'd0, vecs[i].exp_mis});
         chk({vecs[i].name, "_data"}, rdv, vecs[i].exp_data);
         if (vecs[i].exp_mis) chk({vecs[i].name, "_mis_width"}, {31'd0, mis2}, 32'd0);
      end

      // Reset lands on the access edge of the second store: that store must be lost.
      do_op(1'b0, 1'b1, 32'h20, 32'h11111111, 3'b010, st, rdv, mis, mis2, to);
      chk("t5_sw1_stall", 32'(st), 32'd3);
      @(negedge clk);
      MemWriteM = 1'b1; AddrM = 32'h20; WriteDataM = 32'h22222222; Funct3M = 3'b010;
      #1; chk("t5_stall_req", {31'd0, StallMem}, 32'd1);
      @(negedge clk); #1; chk("t5_stall_wait1", {31'd0, StallMem}, 32'd1);
      @(negedge clk); reset = 1'b1; #1;
      @(negedge clk); reset = 1'b0; clear_inputs(); #1;
      chk("t5_stall_after_rst", {31'd0, StallMem}, 32'd0);
      chk("t5_rdata_after_rst", ReadDataM, 32'h0);
      @(negedge clk); #1;
      chk("t5_stall_idle", {31'd0, StallMem}, 32'd0);
      do_op(1'b1, 1'b0, 32'h20, 32'h0, 3'b010, st, rdv, mis, mis2, to);
      chk("t5_lw_stall", 32'(st), 32'd3);
      chk("t5_lw_data", rdv, 32'h11111111);
      model_last = 32'h11111111;

      // Random traffic over bytes 0x100..0x13F, aliased through random upper address bits.
      for (int w = 0; w < 16; w++) begin
         logic [31:0] d = $urandom;
         do_op(1'b0, 1'b1, 32'h100 + 32'(4 * w), d, 3'b010, st, rdv, mis, mis2, to);
         chk("init_stall", 32'(st), 32'd3);
         for (int b = 0; b < 4; b++) model_mem[32'h100 + 4 * w + b] = d[8*b +: 8];
      end
      for (int k = 0; k < 80; k++) begin
         int          sel = $urandom_range(0, 3);
         logic        rd = (sel != 2);
         logic        wr = (sel >= 2);
         logic [2:0]  f3 = wr ? 3'($urandom_range(0, 2)) : ld_f3[$urandom_range(0, 4)];
         int          off = $urandom_range(0, 63);
         logic [31:0] a, wd;
         int          n = size_of(f3);
         logic        ok;
         if ($urandom_range(0, 1) == 1) off = off - (off % n);
         a  = 32'h100 + 32'(off) + (32'($urandom_range(0, 15)) << 12);
         wd = $urandom;
         ok = (a % n) == 0;
         if (ok && wr) begin
            for (int i = 0; i < n; i++) model_mem[(a + i) % 4096] = wd[8*i +: 8];
         end else if (ok && rd) begin
            model_last = model_load(a, f3);
         end
         exp_q.push_back(model_last);
         do_op(rd, wr, a, wd, f3, st, rdv, mis, mis2, to);
         chk("rnd_timeout", {31'd0, to}, 32'd0);
         chk("rnd_stall", 32'(st), ok ? 32'd3 : 32'd0);
         chk("rnd_mis", {31'd0, mis}, {31'd0, ~ok});
         chk("rnd_data", rdv, exp_q.pop_front());
      end

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
